// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Keymap, FSM states and per-scan classification.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD
  } state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_e;

  // KEYMAP[row][col] -> hex code printed on the key.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  localparam logic [3:0] COL_RESET = 4'b1110;

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to all-ones, matching idle pulled-up keypad rows.
module keypad_scanner_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Shift the raw input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x4 keypad scanner with whole-scan debounce.
// Emits a one-cycle key_valid pulse with the accepted hex key code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_TARGET  = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_q, col_d;
  logic [11:0]   samp_q, samp_d;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;

  logic          sample;
  logic          scan_end;
  logic [15:0]   full;
  logic [4:0]    nclosed;
  logic [3:0]    res_code;
  scan_e         res;

  keypad_scanner_sync #(.WIDTH(4)) u_row_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row),
    .q       (row_s)
  );

  // Column dwell timing; sample rows on the last dwell cycle.
  always_comb begin
    sample   = (dwell_q == DWELL_LAST);
    scan_end = sample && !col_q[3];
    dwell_d  = sample ? '0 : dwell_q + DW'(1);
    col_d    = sample ? {col_q[2:0], col_q[3]} : col_q;
    samp_d   = sample ? {~row_s, samp_q[11:4]} : samp_q;
    full     = {~row_s, samp_q};
  end

  // Classify the 16 closure samples of the scan just finished.
  always_comb begin
    nclosed  = '0;
    res_code = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (full[c*4+r]) begin
          nclosed  = nclosed + 5'd1;
          res_code = KEYMAP[r][c];
        end
      end
    end
    if (nclosed == 5'd0)
      res = NONE;
    else if (nclosed == 5'd1)
      res = SINGLE;
    else
      res = MULTI;
  end

  // Debounce FSM, stepped once per completed scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        IDLE: begin
          if (res == SINGLE) begin
            cand_d = res_code;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              code_d  = res_code;
              valid_d = 1'b1;
              rel_d   = '0;
            end else begin
              state_d = PRESS;
            end
          end
        end
        PRESS: begin
          if (res != SINGLE) begin
            state_d = IDLE;
          end else if (res_code != cand_q) begin
            cand_d = res_code;
            cnt_d  = CW'(1);
          end else if (cnt_q + CW'(1) == DB_TARGET) begin
            state_d = HELD;
            code_d  = cand_q;
            valid_d = 1'b1;
            rel_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HELD: begin
          if (res != NONE) begin
            rel_d = '0;
          end else if (rel_q + CW'(1) == DB_TARGET) begin
            state_d = IDLE;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scanner and FSM state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= '0;
      col_q   <= COL_RESET;
      samp_q  <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
      samp_q  <= samp_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_down  = (state_q == HELD);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the seven-segment display path. The display multiplexes outputs across anodes; this block multiplexes a 4x4 matrix keypad (Pmod KYPD) across columns and reads back its rows.
- Drives one column low at a time, samples the synchronized rows, and debounces across whole scans.
- Emits a 4-bit hex key code with a one-cycle valid pulse.
- Feeds stopwatch and other lab tops as a numeric/command entry source.

Parameters:
- SCAN_CYCLES, 100000, clk cycles each column is driven (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- row  input  4  keypad rows, pulled up externally; low = key closed in the driven column; asynchronous to clk
- col  output  4  keypad column drive, active low, exactly one bit low at any time
- key_code  output  4  hex value of the last accepted key; held until the next accepted key
- key_valid  output  1  one-cycle pulse when a new key is accepted
- key_down  output  1  high while the accepted key is held (HELD state)

Behaviour:
- Reset (async assert, sync release):
  - col=4'b1110, key_code=0, key_valid=0, key_down=0.
  - Dwell counter=0, column index=0, FSM=IDLE, debounce count=0, synchronizer flops=4'b1111.
- Row input: 2-FF synchronizer on all 4 bits. Sampled only on the last cycle of each column dwell, giving >= 2 cycles of settle after the column change.
- Scan:
  - Column index advances 0,1,2,3,0 every SCAN_CYCLES cycles.
  - col = ~(1 << index).
  - One full scan = 4*SCAN_CYCLES cycles. "Scan end" = the sample cycle of column 3.
- Scan result, computed at scan end from the 16 accumulated samples:
  - NONE: 0 closures.
  - SINGLE(code): exactly 1 closure.
  - MULTI: 2 or more closures.
- Keymap, key at [row r][col c]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
  - Code = hex value of the label (e.g. r3c1 = 4'hF).
- FSM, evaluated only at scan end:
  - IDLE:
    - SINGLE(k) -> PRESS with cand=k, cnt=1.
    - If DEBOUNCE_SCANS==1, go directly to HELD.
    - NONE or MULTI -> stay.
  - PRESS:
    - SINGLE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS -> HELD.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> rel+1; when rel reaches DEBOUNCE_SCANS -> IDLE.
    - Any other result -> rel=0, stay.
    - No rollover: a second key pressed while holding is ignored until a full release.
- Output timing:
  - On the PRESS->HELD transition, key_code<=cand and key_valid=1 on the cycle after scan end (registered), for exactly 1 cycle.
  - key_down rises with key_valid and falls on the cycle after the releasing scan end.
  - Press-to-valid latency = DEBOUNCE_SCANS full scans, measured from the first scan that sees the key, plus 1 cycle.
- key_code is never changed by a release, MULTI, or bounce.
- Reset mid-operation: all state returns to reset values immediately. A key held through reset is re-debounced from IDLE and produces a fresh key_valid.
- Counter widths:
  - Dwell counter: $clog2(SCAN_CYCLES).
  - Debounce counters: $clog2(DEBOUNCE_SCANS+1).
  - No overflow is possible.

Decomposition:
- keypad_pkg:
  - state enum {IDLE, PRESS, HELD}.
  - scan-result enum {NONE, SINGLE, MULTI}.
  - KEYMAP constant: 4x4 array of logic [3:0].
  - COL_RESET=4'b1110.
- One sub-module: synchronizer (parameterized width, 2 flops, async active-low reset to all-ones), instanced on row.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=2, so 16-cycle scans):
- Reset/idle: hold reset_n=0, rows=4'hF, then release -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; key_code=0.
- Clean press: model asserts row[1] low whenever col[2] is low, for 5 scans, then releases -> one key_valid, key_code=4'h6, 1 cycle after the 2nd scan end; key_down high until 1 cycle after the 2nd all-NONE scan end.
- Bounce: key r3c0 present in scan 1, absent in scan 2, present in scans 3-4 -> single key_valid with code 4'h0 after scan 4 end; no pulse after scan 1.
- Multi-key: r0c0 and r0c1 both pressed for 6 scans -> no key_valid; key_code unchanged.
- Hold then second key: hold r0c3 (A) and get valid, then add r2c2 while still holding A -> no second pulse. Release both for 2 scans, then press r2c2 for 2 scans -> key_valid, code 4'h9.
- Async reset mid-HELD: pull reset_n low for 3 cycles while key D (r3c3) is held -> key_down=0, key_code=0, col=1110 immediately; after release, new key_valid with code 4'hD after 2 scans.
